rv_multicycle_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the RV32I datapath. Steps each instruction through fetch, decode, execute, memory and writeback over a shared single-port memory, and drives the write enables for the IR, PC and register file. Works alongside the combinational opcode decoder, which still supplies mux selects and ALU ops. Detects illegal opcodes and memory timeouts and then parks in a trap state.

---
 rtl/rv_multicycle_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_rv_multicycle_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_sequencer.sv
// rtl/rv_multicycle_sequencer.sv - RV32I multi-cycle sequencer FSM; define RV_SEQ_INSTRET_EN for the instret counter
module rv_multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic        branch_taken,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_take_target,
    output logic        rf_we,
    output logic        retire,
    output logic        trap,
    output logic [2:0]  state
`ifdef RV_SEQ_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_DECODE     = 3'd2,
        S_EXECUTE    = 3'd3,
        S_MEM        = 3'd4,
        S_MEM_WAIT   = 3'd5,
        S_WRITEBACK  = 3'd6,
        S_TRAP       = 3'd7
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    state_t          state_q;
    state_t          state_d;
    logic [6:0]      op_q;
    logic [TO_W-1:0] to_cnt;
    logic            to_expired;
    logic            legal;
    logic            in_mem_state;

    logic req_c;
    logic we_c;
    logic sel_c;
    logic ir_we_c;
    logic pc_we_c;
    logic ptt_c;
    logic rf_we_c;
    logic retire_c;

    // to_cnt counts cycles already spent in the current state, so the
    // MEM_TIMEOUT-th cycle is the one where it reads MEM_TIMEOUT-1.
    assign to_expired   = (MEM_TIMEOUT != 0) && (to_cnt == TO_W'(MEM_TIMEOUT - 1));
    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_FETCH_WAIT) ||
                          (state_q == S_MEM)   || (state_q == S_MEM_WAIT);

    // Legality of the instruction presented on opcode/func3 during DECODE
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OPIMM: legal = 1'b1;
            OPC_LOAD:   legal = !((func3 == 3'd3) || (func3 == 3'd6) || (func3 == 3'd7));
            OPC_STORE:  legal = (func3 <= 3'd2);
            OPC_BRANCH: legal = !((func3 == 3'd2) || (func3 == 3'd3));
            default:    legal = 1'b0;
        endcase
    end

    // Next-state and per-state control outputs
    always_comb begin
        state_d  = state_q;
        req_c    = 1'b0;
        we_c     = 1'b0;
        sel_c    = 1'b0;
        ir_we_c  = 1'b0;
        pc_we_c  = 1'b0;
        ptt_c    = 1'b0;
        rf_we_c  = 1'b0;
        retire_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_gnt)         state_d = S_FETCH_WAIT;
                else if (to_expired) state_d = S_TRAP;
            end
            S_FETCH_WAIT: begin
                if (mem_rvalid) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end else if (to_expired) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                state_d = legal ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                if (op_q == OPC_BRANCH) begin
                    pc_we_c  = 1'b1;
                    ptt_c    = branch_taken;
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else if ((op_q == OPC_LOAD) || (op_q == OPC_STORE)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                req_c = 1'b1;
                sel_c = 1'b1;
                we_c  = (op_q == OPC_STORE);
                if (mem_gnt)         state_d = S_MEM_WAIT;
                else if (to_expired) state_d = S_TRAP;
            end
            S_MEM_WAIT: begin
                if (mem_rvalid) begin
                    if (op_q == OPC_STORE) begin
                        pc_we_c  = 1'b1;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (to_expired) begin
                    state_d = S_TRAP;
                end
            end
            S_WRITEBACK: begin
                rf_we_c  = 1'b1;
                pc_we_c  = 1'b1;
                ptt_c    = (op_q == OPC_JAL) || (op_q == OPC_JALR);
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Opcode latch: later states must not depend on the IR staying put
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    op_q <= '0;
        else if (state_q == S_DECODE)  op_q <= opcode;
    end

    // Memory-wait timeout counter, restarted on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  to_cnt <= '0;
        else if (state_d != state_q) to_cnt <= '0;
        else if (in_mem_state)       to_cnt <= to_cnt + 1'b1;
    end

`ifdef RV_SEQ_INSTRET_EN
    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        instret <= '0;
        else if (retire_c) instret <= instret + 32'd1;
    end
`endif

    // Outputs are held low for the whole time reset is asserted
    assign mem_req        = rst_n & req_c;
    assign mem_we         = rst_n & we_c;
    assign mem_addr_sel   = rst_n & sel_c;
    assign ir_we          = rst_n & ir_we_c;
    assign pc_we          = rst_n & pc_we_c;
    assign pc_take_target = rst_n & ptt_c;
    assign rf_we          = rst_n & rf_we_c;
    assign retire         = rst_n & retire_c;
    assign trap           = rst_n & (state_q == S_TRAP);
    assign state          = state_q;

endmodule

// File: tb/tb_rv_multicycle_sequencer.sv
// tb/tb_rv_multicycle_sequencer.sv - self-checking bench for rv_multicycle_sequencer (honours RV_SEQ_INSTRET_EN)
module tb_rv_multicycle_sequencer;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic       ptt;
        logic       rf_we;
        logic       retire;
        logic       trap;
        logic [2:0] state;
    } outs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, to_rst_n;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       branch_taken, mem_gnt, mem_rvalid, to_gnt, to_rvalid;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_take_target, rf_we, retire, trap;
    logic [2:0] state;
    logic       t_req, t_we, t_sel, t_ir, t_pc, t_ptt, t_rf, t_ret, t_trap;
    logic [2:0] t_state;
`ifdef RV_SEQ_INSTRET_EN
    logic [31:0] instret, t_instret;
`endif

    rv_multicycle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3),
        .branch_taken(branch_taken), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_we(ir_we), .pc_we(pc_we), .pc_take_target(pc_take_target),
        .rf_we(rf_we), .retire(retire), .trap(trap), .state(state)
`ifdef RV_SEQ_INSTRET_EN
        , .instret(instret)
`endif
    );

    rv_multicycle_sequencer #(.MEM_TIMEOUT(4), .TO_W(8)) dut_to (
        .clk(clk), .rst_n(to_rst_n), .opcode(opcode), .func3(func3),
        .branch_taken(branch_taken), .mem_gnt(to_gnt), .mem_rvalid(to_rvalid),
        .mem_req(t_req), .mem_we(t_we), .mem_addr_sel(t_sel),
        .ir_we(t_ir), .pc_we(t_pc), .pc_take_target(t_ptt),
        .rf_we(t_rf), .retire(t_ret), .trap(t_trap), .state(t_state)
`ifdef RV_SEQ_INSTRET_EN
        , .instret(t_instret)
`endif
    );

    outs_t act_o, to_o, exp_o;
    assign act_o = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_take_target, rf_we, retire, trap, state};
    assign to_o  = {t_req, t_we, t_sel, t_ir, t_pc, t_ptt, t_rf, t_ret, t_trap, t_state};

    int         errors = 0;
    int         checks = 0;
    int         exp_instret = 0;
    logic       chk_en = 1'b0;
    string      phase = "init";
    logic [6:0] drv_op;
    logic [2:0] drv_f3;
    logic       drv_tk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic outs_t mk(input logic [2:0] st);
        outs_t o;
        o = '0;
        o.state = st;
        return o;
    endfunction

    function automatic bit spec_legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            LUI, AUIPC, JAL, JALR, OP, OPIMM: return 1'b1;
            LOAD:   return !(f3 inside {3'd3, 3'd6, 3'd7});
            STORE:  return f3 <= 3'd2;
            BRANCH: return !(f3 inside {3'd2, 3'd3});
            default: return 1'b0;
        endcase
    endfunction

    // Per-cycle comparison of the DUT against the model's expected vector
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            check(phase, 32'(act_o), 32'(exp_o));
`ifdef RV_SEQ_INSTRET_EN
            check({phase, "/instret"}, instret, 32'(exp_instret));
            if (exp_o.retire) exp_instret++;
`endif
        end
    end

    task automatic step(input logic g, input logic rv, input outs_t e);
        @(negedge clk);
        mem_gnt      = g;
        mem_rvalid   = rv;
        opcode       = drv_op;
        func3        = drv_f3;
        branch_taken = drv_tk;
        exp_o        = e;
    endtask

    // One instruction: fgd/mgd = cycles before gnt, frd/mrd = cycles before rvalid
    task automatic instr(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic tk,
                         input int fgd, input int frd, input int mgd, input int mrd,
                         input bit noise, input bit abort_mw, output int ncyc);
        outs_t e;
        bit ld, st, br;
        ld = (op == LOAD); st = (op == STORE); br = (op == BRANCH);
        ncyc = 0;
        phase = nm;
        for (int i = 0; i <= fgd; i++) begin
            e = mk(3'd0); e.mem_req = 1'b1;
            step(i == fgd, noise, e); ncyc++;
        end
        for (int i = 0; i <= frd; i++) begin
            e = mk(3'd1); e.ir_we = (i == frd);
            step(noise, i == frd, e); ncyc++;
        end
        drv_op = op; drv_f3 = f3; drv_tk = tk;
        step(noise, noise, mk(3'd2)); ncyc++;
        if (!spec_legal(op, f3)) return;
        e = mk(3'd3);
        if (br) begin e.pc_we = 1'b1; e.ptt = tk; e.retire = 1'b1; end
        step(noise, noise, e); ncyc++;
        if (br) return;
        if (ld || st) begin
            for (int i = 0; i <= mgd; i++) begin
                e = mk(3'd4); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = st;
                step(i == mgd, noise, e); ncyc++;
            end
            for (int i = 0; i <= mrd; i++) begin
                e = mk(3'd5);
                if (st && i == mrd) begin e.pc_we = 1'b1; e.retire = 1'b1; end
                step(noise, i == mrd, e); ncyc++;
                if (abort_mw) return;
            end
            if (st) return;
        end
        e = mk(3'd6); e.rf_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
        e.ptt = (op == JAL) || (op == JALR);
        step(noise, noise, e); ncyc++;
    endtask

    task automatic expect_trap(input int n);
        outs_t e;
        e = mk(3'd7); e.trap = 1'b1;
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        exp_o = mk(3'd0); exp_instret = 0; phase = "in_reset";
        @(posedge clk); #1;
        rst_n = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    logic [6:0] ill_op [9];
    logic [2:0] ill_f3 [9];

    initial begin
        int n;
        rst_n = 1'b0; to_rst_n = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; to_gnt = 1'b0; to_rvalid = 1'b0;
        opcode = '0; func3 = '0; branch_taken = 1'b0;
        drv_op = '0; drv_f3 = '0; drv_tk = 1'b0;
        exp_o = mk(3'd0);
        ill_op = '{7'b1111111, LOAD, LOAD, LOAD, STORE, STORE, BRANCH, BRANCH, 7'b0000000};
        ill_f3 = '{3'd0, 3'd3, 3'd6, 3'd7, 3'd3, 3'd7, 3'd2, 3'd3, 3'd0};

        @(negedge clk); #2;
        check("reset/state", 32'(state), 32'd0);
        check("reset/mem_req", 32'(mem_req), 32'd0);
        check("reset/trap", 32'(trap), 32'd0);
        chk_en = 1'b1;
        do_reset();

        instr("addi",   OPIMM,  3'd0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, n); check("model/addi_cycles", n, 5);
        instr("lw_slow", LOAD,  3'd2, 1'b0, 3, 0, 3, 0, 1'b1, 1'b0, n); check("model/lw_slow_cycles", n, 13);
        instr("beq_t",  BRANCH, 3'd0, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, n); check("model/beq_cycles", n, 4);
        instr("bne_nt", BRANCH, 3'd1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, n);
        instr("sw",     STORE,  3'd2, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, n); check("model/sw_cycles", n, 6);
        instr("lui",    LUI,    3'd5, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, n);
        instr("auipc",  AUIPC,  3'd0, 1'b0, 1, 0, 0, 0, 1'b1, 1'b0, n);
        instr("jal",    JAL,    3'd0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, n);
        instr("jalr",   JALR,   3'd0, 1'b0, 0, 1, 0, 0, 1'b0, 1'b0, n);
        instr("add",    OP,     3'd5, 1'b0, 0, 2, 0, 0, 1'b1, 1'b0, n); check("model/add_cycles", n, 7);
`ifdef RV_SEQ_INSTRET_EN
        @(posedge clk); #1;
        check("instret_after_10", instret, 32'd10);
`endif
        instr("lw",     LOAD,   3'd2, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, n); check("model/lw_cycles", n, 7);
        instr("lhu",    LOAD,   3'd5, 1'b0, 0, 1, 0, 2, 1'b1, 1'b0, n);
        instr("sb",     STORE,  3'd0, 1'b0, 0, 0, 2, 1, 1'b1, 1'b0, n);
        instr("bgeu",   BRANCH, 3'd7, 1'b1, 0, 0, 0, 0, 1'b1, 1'b0, n);

        instr("lw_abort", LOAD, 3'd2, 1'b0, 0, 0, 0, 3, 1'b0, 1'b1, n);
        #3;
        rst_n = 1'b0; exp_o = mk(3'd0); exp_instret = 0;
        #1;
        check("abort/outputs", 32'(act_o), 32'd0);
`ifdef RV_SEQ_INSTRET_EN
        check("abort/instret", instret, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        instr("addi_after_abort", OPIMM, 3'd1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, n);

        for (int k = 0; k < 9; k++) begin
            instr($sformatf("illegal%0d", k), ill_op[k], ill_f3[k], 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, n);
            expect_trap(k == 0 ? 20 : 3);
            #3;
            check($sformatf("illegal%0d/state", k), 32'(state), 32'd7);
            check($sformatf("illegal%0d/trap", k), 32'(trap), 32'd1);
            do_reset();
        end
        chk_en = 1'b0;

        phase = "timeout";
        @(negedge clk); to_gnt = 1'b0; to_rvalid = 1'b0;
        @(posedge clk); #1; to_rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); #2;
            check($sformatf("to_nogrant/cyc%0d_state", i), 32'(to_o.state), 32'd0);
            check($sformatf("to_nogrant/cyc%0d_req", i), 32'(to_o.mem_req), 32'd1);
        end
        @(negedge clk); #2;
        check("to_nogrant/trap_vector", 32'(to_o), 32'({9'b000000001, 3'd7}));
`ifdef RV_SEQ_INSTRET_EN
        check("to_nogrant/instret", t_instret, 32'd0);
`endif
        @(negedge clk); to_rst_n = 1'b0;
        @(posedge clk); #1; to_rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); #2;
            check($sformatf("to_late/cyc%0d_state", i), 32'(to_o.state), 32'd0);
        end
        @(negedge clk); to_gnt = 1'b1; #2;
        check("to_late/gnt_cycle_req", 32'(to_o.mem_req), 32'd1);
        @(negedge clk); to_gnt = 1'b0; #2;
        check("to_late/fetch_wait", 32'(to_o.state), 32'd1);
        check("to_late/no_trap", 32'(to_o.trap), 32'd0);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk); #2;
            check($sformatf("to_rwait/cyc%0d_state", i), 32'(to_o.state), 32'd1);
        end
        @(negedge clk); #2;
        check("to_rwait/trap_state", 32'(to_o.state), 32'd7);
        check("to_rwait/trap", 32'(to_o.trap), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
